aer_in_fifo: RTL
================

AER_IN_FIFO -- requirements
Module: aer_in_fifo

Interface
REQ-001 Parameter M, default 8: neuron address width; event address width is 2*M+1 bits.
REQ-002 Parameter DEPTH, default 8: FIFO entries, power of 2, minimum 2.
REQ-003 CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 SRC_ADDR  input  2*M+1  external event address; stable while SRC_REQ is high.
REQ-006 SRC_REQ  input  1  external 4-phase request; asynchronous to CLK.
REQ-007 SRC_ACK  output  1  external 4-phase acknowledge; registered.
REQ-008 AERIN_ADDR  output  2*M+1  address presented to the core's AER input; registered.
REQ-009 AERIN_REQ  output  1  4-phase request to the core; registered.
REQ-010 AERIN_ACK  input  1  4-phase acknowledge from the core; CLK domain.
REQ-011 FIFO_EMPTY  output  1  high when the FIFO holds 0 entries.
REQ-012 FIFO_FULL  output  1  high when the FIFO holds DEPTH entries.
REQ-013 FIFO_COUNT  output  log2(DEPTH)+1  current FIFO occupancy.

Function
REQ-014 SRC_REQ passes through a 2-flop synchronizer; req_s is SRC_REQ delayed 2 CLK edges.
REQ-015 Input FSM states are I_IDLE and I_WAIT_LOW.
REQ-016 I_IDLE with req_s=1 and FIFO not full: on that edge, write SRC_ADDR at the write pointer, set SRC_ACK=1, go to I_WAIT_LOW.
REQ-017 I_IDLE with req_s=1 and FIFO full: hold state; SRC_ACK stays 0; no write occurs; the event is not dropped.
REQ-018 I_WAIT_LOW with req_s=0: set SRC_ACK=0 and go to I_IDLE; otherwise hold.
REQ-019 Output FSM states are O_IDLE, O_WAIT_ACK and O_WAIT_ACK_LOW.
REQ-020 O_IDLE with FIFO not empty and AERIN_ACK=0: load AERIN_ADDR from the FIFO head, set AERIN_REQ=1, go to O_WAIT_ACK.
REQ-021 O_WAIT_ACK with AERIN_ACK=1: pop the head, set AERIN_REQ=0, go to O_WAIT_ACK_LOW.
REQ-022 The head entry is not removed before the pop in REQ-021; AERIN_ADDR stays stable while AERIN_REQ=1.
REQ-023 O_WAIT_ACK_LOW with AERIN_ACK=0: go to O_IDLE.
REQ-024 Minimum spacing: AERIN_REQ rises no earlier than 1 cycle after AERIN_ACK falls.
REQ-025 Write and pop on the same edge both take effect; FIFO_COUNT is unchanged.
REQ-026 A write while full is impossible by construction.
REQ-027 Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
REQ-028 Ordering is strict FIFO; each accepted event produces exactly one AERIN handshake.
REQ-029 Latency: an entry written at edge k allows AERIN_REQ=1 at edge k+1 at the earliest, provided the output FSM is in O_IDLE and AERIN_ACK=0.
REQ-030 FIFO_EMPTY, FIFO_FULL and FIFO_COUNT are derived from registered state only.

Reset
REQ-031 RST=1 at an edge: SRC_ACK=0, AERIN_REQ=0, AERIN_ADDR=0, pointers=0, FIFO_COUNT=0, FIFO_EMPTY=1, FIFO_FULL=0, synchronizer flops=0, both FSMs idle.
REQ-032 Reset mid-handshake discards buffered events; the FIFO storage array is not cleared.
REQ-033 After RST falls, a SRC_REQ still held high is treated as a new event.

Configuration
REQ-034 Macro AER_IN_REQ_SYNC_EN defined: the synchronizer in REQ-014 is present.
REQ-035 Macro AER_IN_REQ_SYNC_EN undefined: req_s=SRC_REQ directly, with 0 synchronizer delay, for same-clock sources only; all other behaviour is identical.

Verification
REQ-036 Macro defined, empty FIFO, SRC_ADDR=0x1_2345, SRC_REQ rises before edge 1 -> SRC_ACK=1 after edge 3, AERIN_REQ=1 with AERIN_ADDR=0x1_2345 after edge 4.
REQ-037 AERIN_ACK held 0; 8 source events sent -> FIFO_FULL=1 and FIFO_COUNT=8; 9th SRC_REQ receives no SRC_ACK until one AERIN_ACK pulse pops the FIFO.
REQ-038 Addresses 0..19 streamed through DEPTH=8 with random AERIN_ACK delays of 0-5 cycles -> outputs 0..19 in order with no loss or duplication, exercising pointer wrap.
REQ-039 Simultaneous write and pop with FIFO_COUNT=3 -> FIFO_COUNT stays 3 and the next AERIN_ADDR is the correct head.
REQ-040 RST pulsed while AERIN_REQ=1 and FIFO_COUNT=5 -> next edge AERIN_REQ=0, SRC_ACK=0, FIFO_EMPTY=1; a held SRC_REQ is re-accepted after reset.
REQ-041 Macro undefined, same stimulus as REQ-036 -> SRC_ACK=1 after edge 1, AERIN_REQ=1 after edge 2.

Source files
------------

// File: rtl/aer_in_fifo.sv
// rtl/aer_in_fifo.sv - AER event input FIFO bridging an external 4-phase source to the core's AER input
// Optional 2-flop SRC_REQ synchronizer enabled by macro AER_IN_REQ_SYNC_EN.
module aer_in_fifo #(
  parameter int M     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [2*M:0]             SRC_ADDR,
  input  logic                     SRC_REQ,
  output logic                     SRC_ACK,
  output logic [2*M:0]             AERIN_ADDR,
  output logic                     AERIN_REQ,
  input  logic                     AERIN_ACK,
  output logic                     FIFO_EMPTY,
  output logic                     FIFO_FULL,
  output logic [$clog2(DEPTH):0]   FIFO_COUNT
);

  localparam int AW = 2*M + 1;
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef enum logic {I_IDLE, I_WAIT_LOW} in_state_t;
  typedef enum logic [1:0] {O_IDLE, O_WAIT_ACK, O_WAIT_ACK_LOW} out_state_t;

  logic [AW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          req_s;
  logic          push;
  logic          pop;
  in_state_t     in_state;
  out_state_t    out_state;

`ifdef AER_IN_REQ_SYNC_EN
  logic req_meta;
  logic req_sync;

  always_ff @(posedge CLK) begin
    if (RST) begin
      req_meta <= 1'b0;
      req_sync <= 1'b0;
    end else begin
      req_meta <= SRC_REQ;
      req_sync <= req_meta;
    end
  end

  assign req_s = req_sync;
`else
  assign req_s = SRC_REQ;
`endif

  assign FIFO_EMPTY = (count == '0);
  assign FIFO_FULL  = (count == FULL_CNT);
  assign FIFO_COUNT = count;

  // A full FIFO simply stalls the source handshake, so no write can overrun.
  assign push = (in_state == I_IDLE) && req_s && !FIFO_FULL;
  assign pop  = (out_state == O_WAIT_ACK) && AERIN_ACK;

  // Storage is deliberately left uncleared on reset.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= SRC_ADDR;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      in_state <= I_IDLE;
      SRC_ACK  <= 1'b0;
    end else begin
      case (in_state)
        I_IDLE: begin
          if (push) begin
            SRC_ACK  <= 1'b1;
            in_state <= I_WAIT_LOW;
          end
        end
        I_WAIT_LOW: begin
          if (!req_s) begin
            SRC_ACK  <= 1'b0;
            in_state <= I_IDLE;
          end
        end
        default: in_state <= I_IDLE;
      endcase
    end
  end

  // The head stays in the FIFO until acknowledged, so AERIN_ADDR holds while AERIN_REQ is high.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_state  <= O_IDLE;
      AERIN_REQ  <= 1'b0;
      AERIN_ADDR <= '0;
    end else begin
      case (out_state)
        O_IDLE: begin
          if (!FIFO_EMPTY && !AERIN_ACK) begin
            AERIN_ADDR <= mem[rd_ptr];
            AERIN_REQ  <= 1'b1;
            out_state  <= O_WAIT_ACK;
          end
        end
        O_WAIT_ACK: begin
          if (AERIN_ACK) begin
            AERIN_REQ <= 1'b0;
            out_state <= O_WAIT_ACK_LOW;
          end
        end
        O_WAIT_ACK_LOW: begin
          if (!AERIN_ACK) begin
            out_state <= O_IDLE;
          end
        end
        default: out_state <= O_IDLE;
      endcase
    end
  end

endmodule
